// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
//   kp_state_t  : press-tracking FSM states
//   KEY_LUT     : snapshot bit index (row*4+col) -> hex legend
//   onehot16    : true when exactly one key bit is set
//   idx_to_code : snapshot bit index -> hex legend
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HELD  = 2'd2
  } kp_state_t;

  // Physical layout, row 0 first, columns left to right:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  localparam logic [3:0] KEY_LUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic onehot16(input logic [15:0] v);
    return (v != 16'h0) && ((v & (v - 16'h1)) == 16'h0);
  endfunction

  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    return KEY_LUT[idx];
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchroniser for asynchronous keypad row inputs.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input bus
//   q          : synchronised output bus
// Resets to RST_VAL so the idle (pulled-up) level is seen out of reset.
module kp_sync2 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with sweep-level debounce and a single-entry
// valid/ready key output.
//   CLK100MHZ, CPU_RESETN : clock, async active-low reset
//   JA_COL  : column drive, active-low one-hot
//   JA_ROW  : row sense, active-low (pulled up)
//   key_code/key_valid/key_ready : one-deep key holding register
//   key_held : debounced key currently held
//   overflow : sticky, a key was dropped because the register was full
// Optional: define KEYPAD_REPEAT_EN to enable auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_DWELL_CYCLES   = 100000,
  parameter int DEBOUNCE_SCANS     = 8,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  output logic [3:0] JA_COL,
  input  logic [3:0] JA_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int DW = $clog2(COL_DWELL_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  if (COL_DWELL_CYCLES < 4 || DEBOUNCE_SCANS < 1 ||
      REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: invalid parameter value");
  end

  logic [3:0]    row_sync_n, rows;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [15:0]   working, working_nxt, last;
  logic [SW-1:0] stable_cnt;
  logic          sample, sweep_end, debounced, push;
  logic [3:0]    last_idx, latched;
  kp_state_t     state;

  kp_sync2 #(.W(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .d     (JA_ROW),
    .q     (row_sync_n)
  );

  assign rows      = ~row_sync_n;
  assign sample    = (dwell == DWELL_LAST);
  assign sweep_end = sample && (col == 2'd3);
  assign debounced = (stable_cnt == STABLE_MAX);
  assign JA_COL    = ~(4'b0001 << col);

  // Working snapshot with the current column's rows merged in, so the
  // sweep-end compare sees the complete sweep in the same cycle.
  always_comb begin
    working_nxt = working;
    for (int r = 0; r < 4; r++) working_nxt[{r[1:0], col}] = rows[r];
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      dwell      <= '0;
      col        <= '0;
      working    <= '0;
      last       <= '0;
      stable_cnt <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col     <= col + 2'd1;
      working <= working_nxt;
      if (sweep_end) begin
        if (working_nxt == last) begin
          if (!debounced) stable_cnt <= stable_cnt + SW'(1);
        end else begin
          stable_cnt <= SW'(1);
        end
        last <= working_nxt;
      end
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Index of the highest set bit; only meaningful when last is one-hot.
  always_comb begin
    last_idx = 4'd0;
    for (int i = 0; i < 16; i++) if (last[i]) last_idx = i[3:0];
  end

  // Multi-key snapshots never start a press, and once held only a full
  // release re-arms the FSM, so rolling to another key emits nothing.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= S_IDLE;
      latched  <= '0;
      key_held <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (debounced && onehot16(last)) begin
          latched <= idx_to_code(last_idx);
          state   <= S_PRESS;
        end
        S_PRESS: begin
          state    <= S_HELD;
          key_held <= 1'b1;
        end
        S_HELD: if (debounced && (last == 16'h0)) begin
          state    <= S_IDLE;
          key_held <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                        REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed, rpt_push;

  // Sweep counter held at zero outside S_HELD, so it restarts on entry.
  // The first repeat uses the long delay, later ones the rate.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_push  <= 1'b0;
    end else begin
      rpt_push <= 1'b0;
      if (state != S_HELD) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if (sweep_end) begin
        if (rpt_cnt + RW'(1) == (rpt_armed ? RW'(REPEAT_RATE_SCANS)
                                           : RW'(REPEAT_DELAY_SCANS))) begin
          rpt_cnt   <= '0;
          rpt_armed <= 1'b1;
          rpt_push  <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RW'(1);
        end
      end
    end
  end

  assign push = (state == S_PRESS) || (rpt_push && state == S_HELD);
`else
  assign push = (state == S_PRESS);
`endif

  // One-deep holding register: a push into a full, unconsumed entry is
  // dropped; a push coinciding with a handshake replaces the entry.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (push) begin
      if (!key_valid || key_ready) begin
        key_code  <= latched;
        key_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (COL_DWELL_CYCLES=4,
// DEBOUNCE_SCANS=3, so one sweep is 16 cycles). A behavioural keypad
// model pulls rows low for pressed keys in the driven column; expected
// key codes are queued when a press is applied and popped on handshake.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ja_col, ja_row, key_code;
  logic        key_valid, key_ready, key_held, overflow;
  logic [15:0] pressed;

  int          checks  = 0;
  int          passes  = 0;
  int          accepts = 0;
  logic [3:0]  exp_q [$];
  logic [3:0]  exp_code;
  logic [3:0]  col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  keypad_scanner #(
    .COL_DWELL_CYCLES (4),
    .DEBOUNCE_SCANS   (3)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .JA_COL     (ja_col),
    .JA_ROW     (ja_row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_held   (key_held),
    .overflow   (overflow)
  );

  // Keypad matrix: key at (row r, col c) is bit r*4+c of pressed.
  always_comb begin
    ja_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !ja_col[c]) ja_row[r] = 1'b0;
  end

  // Scoreboard: every handshake must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      accepts++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL spurious_accept: got key %0h, wanted no key", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code)
          $display("FAIL accept_code: got %0h, wanted %0h", key_code, exp_code);
        else passes++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (accepts >= target) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_held(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (key_held === lvl) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pressed = '0; key_ready = 1'b0;
    tick(2);
    checks++; if (ja_col !== 4'b1110) $display("FAIL reset_col: got %b, wanted 1110", ja_col); else passes++;
    checks++; if (key_code !== 4'h0) $display("FAIL reset_code: got %0h, wanted 0", key_code); else passes++;
    checks++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b, wanted 0", key_valid); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b, wanted 0", key_held); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, wanted 0", overflow); else passes++;
  endtask

  task automatic test_scan;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (ja_col !== col_seq[(k/4)%4])
        $display("FAIL scan_col[%0d]: got %b, wanted %b", k, ja_col, col_seq[(k/4)%4]);
      else passes++;
      tick(1);
    end
    checks++; if (key_valid !== 1'b0) $display("FAIL idle_valid: got %b, wanted 0", key_valid); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL idle_held: got %b, wanted 0", key_held); else passes++;
  endtask

  task automatic test_single_key;
    int base; bit ok;
    key_ready = 1'b1; base = accepts;
    exp_q.push_back(4'h6);
    pressed[6] = 1'b1;                       // row1/col2
    wait_accepts(base + 1, 160, ok);
    checks++; if (!ok) $display("FAIL key6_accept: got no accept, wanted one"); else passes++;
    checks++; if (key_held !== 1'b1) $display("FAIL key6_held: got %b, wanted 1", key_held); else passes++;
    tick(64);
    checks++; if (accepts !== base + 1) $display("FAIL key6_once: got %0d accepts, wanted %0d", accepts - base, 1); else passes++;
    pressed = '0;
    tick(16);
    checks++; if (key_held !== 1'b1) $display("FAIL key6_held_release: got %b, wanted 1", key_held); else passes++;
    wait_held(1'b0, 128, ok);
    checks++; if (!ok) $display("FAIL key6_unheld: got held 1, wanted 0"); else passes++;
  endtask

  // One toggle per sweep interval makes consecutive sweeps always
  // disagree, so nothing may be accepted until the contact settles.
  task automatic test_bounce;
    int base; bit ok;
    base = accepts;
    for (int i = 0; i < 7; i++) begin
      pressed[0] = ~pressed[0];
      tick(16);
    end
    checks++; if (accepts !== base) $display("FAIL bounce_quiet: got %0d accepts, wanted 0", accepts - base); else passes++;
    exp_q.push_back(4'h1);
    wait_accepts(base + 1, 160, ok);
    checks++; if (!ok) $display("FAIL bounce_accept: got no accept, wanted one"); else passes++;
    tick(64);
    checks++; if (accepts !== base + 1) $display("FAIL bounce_once: got %0d accepts, wanted 1", accepts - base); else passes++;
    pressed = '0;
    wait_held(1'b0, 128, ok);
    checks++; if (!ok) $display("FAIL bounce_unheld: got held 1, wanted 0"); else passes++;
  endtask

  task automatic test_multi_key;
    int base; bit ok;
    base = accepts;
    pressed = 16'h0021;                      // '1' and '5'
    tick(96);
    checks++; if (accepts !== base || key_valid !== 1'b0) $display("FAIL multi_none: got %0d accepts valid %b, wanted 0 and 0", accepts - base, key_valid); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL multi_held: got %b, wanted 0", key_held); else passes++;
    pressed = '0;
    tick(64);
    exp_q.push_back(4'h1);
    pressed[0] = 1'b1;
    wait_accepts(base + 1, 160, ok);
    checks++; if (!ok) $display("FAIL roll_first: got no accept, wanted one"); else passes++;
    pressed[5] = 1'b1;
    tick(64);
    pressed[0] = 1'b0;                       // roll to '5' while held
    tick(96);
    checks++; if (accepts !== base + 1) $display("FAIL roll_ignored: got %0d accepts, wanted 1", accepts - base); else passes++;
    checks++; if (key_held !== 1'b1) $display("FAIL roll_held: got %b, wanted 1", key_held); else passes++;
    pressed = '0;
    wait_held(1'b0, 128, ok);
    checks++; if (!ok || accepts !== base + 1) $display("FAIL roll_release: got ok %b accepts %0d, wanted 1 and 1", ok, accepts - base); else passes++;
  endtask

  task automatic test_overflow;
    int base; bit ok;
    key_ready = 1'b0; base = accepts;
    exp_q.push_back(4'h1);
    pressed[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (key_valid === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
    checks++; if (!ok || key_code !== 4'h1) $display("FAIL ovf_first: got valid %b code %0h, wanted 1 and 1", ok, key_code); else passes++;
    pressed = '0;
    wait_held(1'b0, 128, ok);
    pressed[1] = 1'b1;                       // '2', dropped
    wait_held(1'b1, 160, ok);
    tick(2);
    checks++; if (!ok || overflow !== 1'b1) $display("FAIL ovf_set: got held %b overflow %b, wanted 1 and 1", ok, overflow); else passes++;
    checks++; if (key_code !== 4'h1 || key_valid !== 1'b1) $display("FAIL ovf_keep: got code %0h valid %b, wanted 1 and 1", key_code, key_valid); else passes++;
    pressed = '0;
    wait_held(1'b0, 128, ok);
    checks++; if (accepts !== base) $display("FAIL ovf_no_accept: got %0d accepts, wanted 0", accepts - base); else passes++;
    key_ready = 1'b1;
    tick(1);
    checks++; if (key_valid !== 1'b0) $display("FAIL ovf_drain: got valid %b, wanted 0", key_valid); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, wanted 1", overflow); else passes++;
    checks++; if (accepts !== base + 1) $display("FAIL ovf_accept: got %0d accepts, wanted 1", accepts - base); else passes++;
  endtask

  task automatic test_reset_mid;
    int base; bit ok;
    key_ready = 1'b1; base = accepts;
    pressed[10] = 1'b1;                      // '9'
    tick(24);
    rst_n = 1'b0;
    #1;
    checks++; if (ja_col !== 4'b1110) $display("FAIL mid_reset_col: got %b, wanted 1110", ja_col); else passes++;
    checks++; if ({key_code, key_valid, key_held, overflow} !== 7'd0) $display("FAIL mid_reset_outs: got %b, wanted 0000000", {key_code, key_valid, key_held, overflow}); else passes++;
    tick(3);
    rst_n = 1'b1;
    exp_q.push_back(4'h9);
    tick(40);
    checks++; if (accepts !== base) $display("FAIL mid_early: got %0d accepts, wanted 0", accepts - base); else passes++;
    wait_accepts(base + 1, 64, ok);
    checks++; if (!ok) $display("FAIL mid_accept: got no accept, wanted one"); else passes++;
    tick(32);
    checks++; if (accepts !== base + 1) $display("FAIL mid_once: got %0d accepts, wanted 1", accepts - base); else passes++;
    pressed = '0;
    wait_held(1'b0, 128, ok);
  endtask

  initial begin
    test_reset;
    test_scan;
    test_single_key;
    test_bounce;
    test_multi_key;
    test_overflow;
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drained: got %0d left, wanted 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
